// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: valid/ready handshake, 2-entry skid buffer, synchronous flush, write-back mux.
// Optional: define MEM_WB_PERF_EN to add the stall_cycles counter and its perf_clr input.
module mem_wb_pipe #(
   parameter int DATA_W          = 32,
   parameter int REG_AW          = 5,
   parameter int FLUSH_KEEP_SKID = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] mem_read,
   input  logic [REG_AW-1:0] RegDst,
   input  logic              MemtoReg,
   input  logic              RegWrite,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_out_wb,
   output logic [DATA_W-1:0] mem_read_out,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] RegDst_out,
   output logic              MemtoReg_out,
   output logic              RegWrite_out
`ifdef MEM_WB_PERF_EN
   ,
   input  logic              perf_clr,
   output logic [31:0]       stall_cycles
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mem;
      logic [REG_AW-1:0] dst;
      logic              m2r;
      logic              rw;
   } entry_t;

   entry_t main_q, skid_q, in_entry;
   logic   main_v, skid_v, ready_q;
   logic   main_v_d, skid_v_d;
   logic   load_main, load_skid, move_skid;
   logic   accept, drain;

   assign in_entry = '{alu: ALUResult, mem: mem_read, dst: RegDst, m2r: MemtoReg, rw: RegWrite};
   assign accept   = in_valid & ready_q;
   assign drain    = main_v & out_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      main_v_d  = main_v;
      skid_v_d  = skid_v;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      if (flush) begin
         skid_v_d = 1'b0;
         if ((FLUSH_KEEP_SKID != 0) && skid_v) begin
            main_v_d  = 1'b1;
            move_skid = 1'b1;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (skid_v) begin
         if (drain) begin
            move_skid = 1'b1;
            skid_v_d  = 1'b0;
         end
      end else if (main_v) begin
         if (accept && drain) begin
            load_main = 1'b1;
         end else if (accept) begin
            load_skid = 1'b1;
            skid_v_d  = 1'b1;
         end else if (drain) begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         load_main = 1'b1;
         main_v_d  = 1'b1;
      end
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_v  <= 1'b0;
         skid_v  <= 1'b0;
         ready_q <= 1'b0;
         // NOTE: the data entries are reset as well so the outputs read 0, not stale data, during reset.
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         main_v  <= main_v_d;
         skid_v  <= skid_v_d;
         ready_q <= ~skid_v_d;
         if (load_main) begin
            main_q <= in_entry;
         end else if (move_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   // in_ready is a register mirroring ~skid_v, so out_ready never reaches it combinationally.
   assign in_ready     = ready_q;
   assign out_valid    = main_v;
   assign alu_out_wb   = main_q.alu;
   assign mem_read_out = main_q.mem;
   assign RegDst_out   = main_q.dst;
   assign MemtoReg_out = main_q.m2r;
   assign RegWrite_out = main_q.rw & main_v;
   assign wb_data      = main_q.m2r ? main_q.mem : main_q.alu;

`ifdef MEM_WB_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (perf_clr) begin
         stall_q <= '0;
      end else if (main_v && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: both flush modes side by side, each against a queue-based reference model.
module tb_mem_wb_pipe;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  dst;
      logic        m2r;
      logic        rw;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] ALUResult = '0;
   logic [31:0] mem_read = '0;
   logic [4:0]  RegDst = '0;
   logic        MemtoReg = 1'b0;
   logic        RegWrite = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        perf_clr = 1'b0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_dut
      logic        in_ready, out_valid, MemtoReg_out, RegWrite_out;
      logic [31:0] alu_out_wb, mem_read_out, wb_data;
      logic [4:0]  RegDst_out;
`ifdef MEM_WB_PERF_EN
      logic [31:0] stall_cycles;
`endif

      mem_wb_pipe #(.DATA_W(32), .REG_AW(5), .FLUSH_KEEP_SKID(k)) dut (
         .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
         .ALUResult(ALUResult), .mem_read(mem_read), .RegDst(RegDst),
         .MemtoReg(MemtoReg), .RegWrite(RegWrite), .flush(flush),
         .out_valid(out_valid), .out_ready(out_ready), .alu_out_wb(alu_out_wb),
         .mem_read_out(mem_read_out), .wb_data(wb_data), .RegDst_out(RegDst_out),
         .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out)
`ifdef MEM_WB_PERF_EN
         , .perf_clr(perf_clr), .stall_cycles(stall_cycles)
`endif
      );

      // Reference model: the in-flight instructions as an ordered queue (front = WB entry).
      entry_t      q[$];
      bit          up = 1'b0;
      int unsigned stalls = 0;

      initial begin
         bit     acc;
         entry_t e;
         forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
               q.delete();
               up     = 1'b0;
               stalls = 0;
            end else begin
               acc = in_valid && up && (q.size() < 2);
               if (perf_clr) stalls = 0;
               else if (q.size() > 0 && !out_ready && stalls != 32'hFFFF_FFFF) stalls++;
               if (flush) begin
                  if (k != 0) begin
                     if (q.size() > 0) void'(q.pop_front());
                  end else begin
                     q.delete();
                  end
               end else begin
                  if (q.size() > 0 && out_ready) void'(q.pop_front());
                  if (acc) begin
                     e = '{ALUResult, mem_read, RegDst, MemtoReg, RegWrite};
                     q.push_back(e);
                  end
               end
               up = 1'b1;
            end
         end
      end

      // Monitor: compares the presented WB entry and handshake against the model every cycle.
      initial begin
         forever begin
            @(negedge clk);
            if (reset) begin
               check($sformatf("k%0d in_ready", k), in_ready, up && q.size() < 2);
               check($sformatf("k%0d out_valid", k), out_valid, q.size() > 0);
               check($sformatf("k%0d RegWrite_out", k), RegWrite_out, q.size() > 0 && q[0].rw);
               if (q.size() > 0) begin
                  check($sformatf("k%0d entry", k), {alu_out_wb, mem_read_out, RegDst_out, MemtoReg_out},
                        {q[0].alu, q[0].mem, q[0].dst, q[0].m2r});
                  check($sformatf("k%0d wb_data", k), wb_data, q[0].m2r ? q[0].mem : q[0].alu);
               end
`ifdef MEM_WB_PERF_EN
               check($sformatf("k%0d stall_cycles", k), stall_cycles, stalls);
`endif
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] m, input logic [4:0] d,
                        input bit m2r, input bit rw, input bit ordy, input bit fl);
      in_valid  = v;
      ALUResult = a;
      mem_read  = m;
      RegDst    = d;
      MemtoReg  = m2r;
      RegWrite  = rw;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit ordy);
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst in_ready", g_dut[0].in_ready, 1'b0);
      check("rst out_valid", g_dut[0].out_valid, 1'b0);
      check("rst wb_data", g_dut[0].wb_data, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("release in_ready", g_dut[0].in_ready, 1'b1);

      // Single ALU write-back.
      drive(1'b1, 32'h0000_1234, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0);
      check("basic out_valid", g_dut[0].out_valid, 1'b1);
      check("basic wb_data", g_dut[0].wb_data, 32'h0000_1234);
      check("basic RegDst_out", g_dut[0].RegDst_out, 5'd7);
      check("basic RegWrite_out", g_dut[0].RegWrite_out, 1'b1);
      idle(1'b1);

      // Back-pressure fills the skid entry, then drains in order.
      drive(1'b1, 32'd1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'd2, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("bp in_ready full", g_dut[0].in_ready, 1'b0);
      check("bp first", g_dut[0].alu_out_wb, 32'd1);
      idle(1'b1);
      check("bp second", g_dut[0].alu_out_wb, 32'd2);
      check("bp in_ready back", g_dut[0].in_ready, 1'b1);
      idle(1'b1);

      // Load data selected for write-back.
      drive(1'b1, 32'h10, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      check("load wb_data", g_dut[0].wb_data, 32'hDEAD_BEEF);
      check("load alu_out_wb", g_dut[0].alu_out_wb, 32'h10);
      idle(1'b1);

      // Flush in FULL with a simultaneous input.
      drive(1'b1, 32'hA1, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'hB2, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'hC3, 32'h0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
      check("flush0 out_valid", g_dut[0].out_valid, 1'b0);
      check("flush0 RegWrite_out", g_dut[0].RegWrite_out, 1'b0);
      check("flush0 in_ready", g_dut[0].in_ready, 1'b1);
      check("flush1 out_valid", g_dut[1].out_valid, 1'b1);
      check("flush1 kept skid", g_dut[1].alu_out_wb, 32'hB2);
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset while FULL.
      drive(1'b1, 32'h55, 32'h66, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h77, 32'h88, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("arst out_valid", g_dut[0].out_valid, 1'b0);
      check("arst RegWrite_out", g_dut[0].RegWrite_out, 1'b0);
      check("arst wb_data", g_dut[0].wb_data, 32'h0);
      check("arst mem_read_out", g_dut[1].mem_read_out, 32'h0);
      check("arst in_ready", g_dut[1].in_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1'b1);
      check("arst no stale", g_dut[0].out_valid, 1'b0);

`ifdef MEM_WB_PERF_EN
      perf_clr = 1'b1;
      idle(1'b1);
      perf_clr = 1'b0;
      drive(1'b1, 32'h99, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) idle(1'b0);
      check("perf five stalls", g_dut[0].stall_cycles, 32'd5);
      perf_clr = 1'b1;
      idle(1'b0);
      perf_clr = 1'b0;
      check("perf clear wins", g_dut[0].stall_cycles, 32'd0);
      idle(1'b1);
`endif

      // Randomized traffic, checked by the monitors.
      repeat (600) begin
         perf_clr = ($urandom_range(0, 29) == 0);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom),
               1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end
      perf_clr = 1'b0;
      repeat (4) idle(1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a write-back select.
- Sits between the data-memory stage and the register-file write port.
- Replaces the fixed-width, always-advancing MEM/WB register; can stall and absorb back-pressure without combinational ready paths.

Parameters:
- DATA_W, 32, width of the ALU result and memory read data
- REG_AW, 5, destination register address width
- FLUSH_KEEP_SKID, 0, 1 = flush clears only the output entry, keeping the skid entry

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  MEM stage presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- ALUResult  in  DATA_W  ALU result from MEM
- mem_read  in  DATA_W  load data from MEM
- RegDst  in  REG_AW  destination register
- MemtoReg  in  1  1 = write back load data
- RegWrite  in  1  instruction writes the register file
- flush  in  1  kill all in-flight entries
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumer accepts
- alu_out_wb  out  DATA_W  registered ALU result
- mem_read_out  out  DATA_W  registered load data
- wb_data  out  DATA_W  MemtoReg_out ? mem_read_out : alu_out_wb (combinational from registers)
- RegDst_out  out  REG_AW  registered destination
- MemtoReg_out  out  1  registered select
- RegWrite_out  out  1  RegWrite of the entry AND out_valid (never 1 when out_valid = 0)

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State is encoded by {main_v, skid_v}:
  - EMPTY = 00
  - ONE = 10
  - FULL = 11
  - 01 is illegal and unreachable.
- in_ready = ~skid_v, and is forced to 0 while reset = 0. Registered state only; no combinational path from out_ready to in_ready.
- out_valid = main_v.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- Transitions (absent flush):
  - EMPTY + accept → ONE; input loads main.
  - ONE + accept + drain → ONE; input loads main.
  - ONE + accept, no drain → FULL; input loads skid.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE; skid moves to main, skid_v clears. in_ready = 0 in FULL, so no accept.
  - Otherwise hold all fields.
- Latency: 1 cycle from accept to out_valid when main is empty or drains the same cycle. Throughput: 1 per cycle with out_ready held high.
- Ordering is strict FIFO; the skid entry is never overtaken by input.
- Flush (synchronous):
  - FLUSH_KEEP_SKID = 0: main_v and skid_v clear at the next edge, and any same-cycle accept is dropped. Flush has priority over accept and drain.
  - FLUSH_KEEP_SKID = 1: main is dropped; the skid entry, if any, moves to main. Same-cycle input is dropped.
- Data fields of invalid entries hold their last value, except RegWrite_out, which is gated by out_valid.
- Reset (async assert, sync release by the external synchroniser):
  - main_v = skid_v = 0.
  - alu_out_wb, mem_read_out, wb_data = 0; RegDst_out = 0; MemtoReg_out = 0; RegWrite_out = 0; out_valid = 0; in_ready = 0 while asserted, 1 the cycle after release.
  - Reset mid-transfer discards both entries; nothing is written back.
- Width rules: all data paths are exactly DATA_W wide with no extension or truncation. wb_data is a pure 2:1 mux.

Optional Feature:
- Macro: MEM_WB_PERF_EN.
- Defined: adds output stall_cycles [31:0] and input perf_clr [0:0].
  - Counter increments on every cycle with out_valid & ~out_ready, saturating at 32'hFFFF_FFFF.
  - perf_clr = 1 zeroes it at the next edge; clear wins over increment.
  - Reset value is 0.
- Undefined: ports and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then in_valid=1, ALUResult=32'h0000_1234, RegDst=5'd7, RegWrite=1, MemtoReg=0, out_ready=1 → next cycle out_valid=1, wb_data=32'h0000_1234, RegDst_out=7, RegWrite_out=1.
- Back-pressure: out_ready=0, send A (ALUResult=1) then B (ALUResult=2) → in_ready=0 after B. Raise out_ready → outputs show 1 then 2 on consecutive cycles, in_ready returns to 1.
- Load select: MemtoReg=1, mem_read=32'hDEAD_BEEF, ALUResult=32'h10 → wb_data=32'hDEAD_BEEF, alu_out_wb=32'h10.
- Flush in FULL with FLUSH_KEEP_SKID=0 and a simultaneous in_valid → next cycle out_valid=0, RegWrite_out=0, in_ready=1. Repeat with FLUSH_KEEP_SKID=1 → out_valid=1 carrying the former skid entry.
- Async reset asserted mid-stream in FULL → outputs go to 0 immediately (before the next clk edge). After release, no stale entry appears.
- MEM_WB_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles → stall_cycles=5. perf_clr pulsed in the same cycle as a stall → stall_cycles=0.
